// File: rtl/alu_operand_stage_pkg.sv
// rtl/alu_operand_stage_pkg.sv - opcode, ALU code constants and funch translation shared by the operand stage
package alu_operand_stage_pkg;

   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_OP_IMM = 5'b00100;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;

   localparam logic [6:0] FUNCH_BASE   = 7'b0000000;
   localparam logic [6:0] FUNCH_ALT    = 7'b0100000;
   localparam logic [6:0] FUNCH_MULDIV = 7'b0000001;

   localparam logic [2:0] FUNC_ADD = 3'b000;
   localparam logic [2:0] FUNC_SLL = 3'b001;
   localparam logic [2:0] FUNC_SR  = 3'b101;

   typedef struct packed {
      logic [6:0] funch;
      logic [2:0] func;
   } alu_code_t;

   localparam alu_code_t ALU_ADD = '{funch: FUNCH_BASE, func: FUNC_ADD};

   // The ALU encodes logical right shift with ALT and arithmetic with BASE, the reverse of RISC-V.
   function automatic logic [6:0] translate_shift_funch(input logic [6:0] funct7);
      logic [6:0] res;
      res = funct7;
      if (funct7 == FUNCH_BASE) begin
         res = FUNCH_ALT;
      end else if (funct7 == FUNCH_ALT) begin
         res = FUNCH_BASE;
      end
      return res;
   endfunction

endpackage

// File: rtl/alu_operand_stage_imm_gen.sv
// rtl/alu_operand_stage_imm_gen.sv - combinational I-type, U-type and shift-amount immediate extraction
module alu_operand_stage_imm_gen
   import alu_operand_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:12]     instr_hi,
   output logic [XLEN-1:0]  imm_i,
   output logic [XLEN-1:0]  imm_u,
   output logic [4:0]       shamt
);

   assign imm_i = {{(XLEN-12){instr_hi[31]}}, instr_hi[31:20]};
   assign imm_u = {instr_hi[31:12], 12'b0};
   assign shamt = instr_hi[24:20];

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - execute-entry register: decode, operand select with forwarding, ALU code translation
module alu_operand_stage
   import alu_operand_stage_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter bit FWD_ENABLE = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [XLEN-1:0]  pc,
   output logic [4:0]       rs1_addr,
   output logic [4:0]       rs2_addr,
   input  logic [XLEN-1:0]  rs1_data,
   input  logic [XLEN-1:0]  rs2_data,
   input  logic             fwd_valid,
   input  logic [4:0]       fwd_rd,
   input  logic [XLEN-1:0]  fwd_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       alu_func,
   output logic [6:0]       alu_funch,
   output logic [4:0]       alu_mode,
   output logic [XLEN-1:0]  alu_in1,
   output logic [XLEN-1:0]  alu_in2,
   output logic [4:0]       out_rd,
   output logic             out_illegal
);

   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_u;
   logic [4:0]      shamt;

   alu_operand_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr_hi (instr[31:12]),
      .imm_i    (imm_i),
      .imm_u    (imm_u),
      .shamt    (shamt)
   );

   logic unused_instr_size;
   assign unused_instr_size = &{1'b0, instr[1:0]};

   assign rs1_addr = instr[19:15];
   assign rs2_addr = instr[24:20];

   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;

   always_comb begin
      rs1_val = rs1_data;
      rs2_val = rs2_data;
      if (FWD_ENABLE && fwd_valid && (fwd_rd != 5'd0)) begin
         if (fwd_rd == rs1_addr) rs1_val = fwd_data;
         if (fwd_rd == rs2_addr) rs2_val = fwd_data;
      end
      if (rs1_addr == 5'd0) rs1_val = '0;
      if (rs2_addr == 5'd0) rs2_val = '0;
   end

   logic [4:0]      mode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic            dec_legal;
   alu_code_t       dec_code;
   logic [XLEN-1:0] dec_in1;
   logic [XLEN-1:0] dec_in2;
   logic [4:0]      dec_rd;

   assign mode   = instr[6:2];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   always_comb begin
      dec_legal = 1'b0;
      dec_code  = ALU_ADD;
      dec_in1   = '0;
      dec_in2   = '0;
      case (mode)
         OPC_OP: begin
            dec_in1        = rs1_val;
            dec_in2        = rs2_val;
            dec_code.func  = funct3;
            dec_code.funch = funct7;
            dec_legal      = (funct7 == FUNCH_BASE) || (funct7 == FUNCH_MULDIV) ||
                             ((funct7 == FUNCH_ALT) && ((funct3 == FUNC_ADD) || (funct3 == FUNC_SR)));
            if (funct7 != FUNCH_MULDIV) begin
               if (funct3 == FUNC_SR) dec_code.funch = translate_shift_funch(funct7);
               if ((funct3 == FUNC_SLL) || (funct3 == FUNC_SR)) begin
                  dec_in2 = {{(XLEN-5){1'b0}}, rs2_val[4:0]};
               end
            end
         end
         OPC_OP_IMM: begin
            dec_in1        = rs1_val;
            dec_in2        = imm_i;
            dec_code.func  = funct3;
            dec_code.funch = FUNCH_BASE;
            dec_legal      = 1'b1;
            if (funct3 == FUNC_SLL) begin
               dec_in2   = {{(XLEN-5){1'b0}}, shamt};
               dec_legal = (funct7 == FUNCH_BASE);
            end else if (funct3 == FUNC_SR) begin
               dec_in2        = {{(XLEN-5){1'b0}}, shamt};
               dec_legal      = (funct7 == FUNCH_BASE) || (funct7 == FUNCH_ALT);
               dec_code.funch = translate_shift_funch(funct7);
            end
         end
         OPC_LUI: begin
            dec_in2   = imm_u;
            dec_legal = 1'b1;
         end
         OPC_AUIPC: begin
            dec_in1   = pc;
            dec_in2   = imm_u;
            dec_legal = 1'b1;
         end
         default: begin
            dec_legal = 1'b0;
         end
      endcase
      // Illegal encodings collapse to a harmless ADD of zeros with no destination.
      if (!dec_legal) begin
         dec_code = ALU_ADD;
         dec_in1  = '0;
         dec_in2  = '0;
      end
      dec_rd = dec_legal ? instr[11:7] : 5'd0;
   end

   logic            out_valid_q,   out_valid_d;
   logic            out_illegal_q, out_illegal_d;
   alu_code_t       code_q,        code_d;
   logic [4:0]      mode_q,        mode_d;
   logic [XLEN-1:0] in1_q,         in1_d;
   logic [XLEN-1:0] in2_q,         in2_d;
   logic [4:0]      rd_q,          rd_d;
   logic            accept;

   assign in_ready = !flush && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d   = out_valid_q;
      out_illegal_d = out_illegal_q;
      code_d        = code_q;
      mode_d        = mode_q;
      in1_d         = in1_q;
      in2_d         = in2_q;
      rd_d          = rd_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d   = 1'b1;
         out_illegal_d = !dec_legal;
         code_d        = dec_code;
         mode_d        = mode;
         in1_d         = dec_in1;
         in2_d         = dec_in2;
         rd_d          = dec_rd;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q   <= 1'b0;
         out_illegal_q <= 1'b0;
         code_q        <= '0;
         mode_q        <= '0;
         in1_q         <= '0;
         in2_q         <= '0;
         rd_q          <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_illegal_q <= out_illegal_d;
         code_q        <= code_d;
         mode_q        <= mode_d;
         in1_q         <= in1_d;
         in2_q         <= in2_d;
         rd_q          <= rd_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_illegal = out_illegal_q;
   assign alu_func    = code_q.func;
   assign alu_funch   = code_q.funch;
   assign alu_mode    = mode_q;
   assign alu_in1     = in1_q;
   assign alu_in2     = in2_q;
   assign out_rd      = rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - vector table, hand sequences and randomized model comparison for alu_operand_stage
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  alu_func;
   logic [6:0]  alu_funch;
   logic [4:0]  alu_mode;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [4:0]  out_rd;
   logic        out_illegal;

   logic [31:0] rf [32];

   assign rs1_data = rf[rs1_addr];
   assign rs2_data = rf[rs2_addr];

   always #5 clk = ~clk;

   alu_operand_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .fwd_valid(fwd_valid),
      .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .alu_func(alu_func),
      .alu_funch(alu_funch), .alu_mode(alu_mode), .alu_in1(alu_in1),
      .alu_in2(alu_in2), .out_rd(out_rd), .out_illegal(out_illegal)
   );

   typedef struct {
      logic        ill;
      logic [6:0]  funch;
      logic [2:0]  func;
      logic [4:0]  mode;
      logic [31:0] in1;
      logic [31:0] in2;
      logic [4:0]  rd;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fv;
      logic [4:0]  frd;
      logic [31:0] fdata;
      exp_t        e;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic check_out(input string tag, input exp_t e);
      chk({tag, " out_valid"},   32'(out_valid),   32'd1);
      chk({tag, " out_illegal"}, 32'(out_illegal), 32'(e.ill));
      chk({tag, " funch"},       32'(alu_funch),   32'(e.funch));
      chk({tag, " func"},        32'(alu_func),    32'(e.func));
      chk({tag, " mode"},        32'(alu_mode),    32'(e.mode));
      chk({tag, " in1"},         alu_in1,          e.in1);
      chk({tag, " in2"},         alu_in2,          e.in2);
      chk({tag, " rd"},          32'(out_rd),      32'(e.rd));
   endtask

   function automatic exp_t mk_exp(input logic ill, input logic [6:0] funch, input logic [2:0] func,
                                   input logic [4:0] mode, input logic [31:0] in1, input logic [31:0] in2,
                                   input logic [4:0] rd);
      exp_t e;
      e.ill = ill; e.funch = funch; e.func = func; e.mode = mode;
      e.in1 = in1; e.in2 = in2; e.rd = rd;
      return e;
   endfunction

   // Reference: operand value as the register file plus writeback bypass would present it.
   function automatic logic [31:0] src_val(input logic [4:0] a, input logic fv, input logic [4:0] frd,
                                           input logic [31:0] fd);
      if (a == 5'd0) return 32'd0;
      if (fv && frd == a) return fd;
      return rf[a];
   endfunction

   function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pcv, input logic fv,
                                      input logic [4:0] frd, input logic [31:0] fd);
      exp_t        e;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] s1;
      logic [31:0] s2;
      logic        ok;
      int          imm;
      f3 = ins[14:12];
      f7 = ins[31:25];
      s1 = src_val(ins[19:15], fv, frd, fd);
      s2 = src_val(ins[24:20], fv, frd, fd);
      e = mk_exp(1'b0, 7'd0, f3, ins[6:2], 32'd0, 32'd0, ins[11:7]);
      ok = 1'b0;
      case (ins[6:2])
         5'b01100: begin
            ok = (f7 == 7'd0) || (f7 == 7'd1) || (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5));
            e.in1 = s1;
            e.in2 = (f7 != 7'd1 && (f3 == 3'd1 || f3 == 3'd5)) ? s2 % 32 : s2;
            if (f3 == 3'd5 && f7 == 7'd0) e.funch = 7'd32;
            else if (f3 == 3'd5 && f7 == 7'd32) e.funch = 7'd0;
            else e.funch = f7;
         end
         5'b00100: begin
            e.in1 = s1;
            imm = int'(ins[31:20]);
            if (imm >= 2048) imm = imm - 4096;
            e.in2 = 32'(imm);
            ok = 1'b1;
            if (f3 == 3'd1) begin
               ok = (f7 == 7'd0);
               e.in2 = 32'(ins[24:20]);
            end else if (f3 == 3'd5) begin
               ok = (f7 == 7'd0) || (f7 == 7'd32);
               e.in2 = 32'(ins[24:20]);
               e.funch = (f7 == 7'd0) ? 7'd32 : 7'd0;
            end
         end
         5'b01101: begin ok = 1'b1; e.func = 3'd0; e.in2 = ins & 32'hFFFF_F000; end
         5'b00101: begin ok = 1'b1; e.func = 3'd0; e.in1 = pcv; e.in2 = ins & 32'hFFFF_F000; end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         e.ill = 1'b1; e.funch = 7'd0; e.func = 3'd0;
         e.in1 = 32'd0; e.in2 = 32'd0; e.rd = 5'd0;
      end
      return e;
   endfunction

   task automatic drive(input logic [31:0] ins, input logic [31:0] pcv, input logic fv,
                        input logic [4:0] frd, input logic [31:0] fd, input logic iv,
                        input logic ordy, input logic fl);
      instr = ins; pc = pcv; fwd_valid = fv; fwd_rd = frd; fwd_data = fd;
      in_valid = iv; out_ready = ordy; flush = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[$];

   localparam logic [31:0] I_ADDI = 32'hFFF0_8293;
   localparam logic [31:0] I_SRAI = 32'h4041_5193;
   localparam logic [31:0] I_LUI  = 32'h1234_53B7;

   initial begin
      exp_t e_a;
      exp_t e_b;
      exp_t e_c;
      exp_t m_e;
      exp_t e_new;
      logic m_valid;
      logic exp_ready;
      logic [31:0] ri;
      logic iv;
      logic ordy;
      logic fl;
      logic fv;
      logic [4:0] frd;
      logic [6:0] f7;

      for (int i = 0; i < 32; i++) rf[i] = i * 32'h1111_1111;
      rf[0] = 32'hBADB_AD00;
      rf[1] = 32'h0000_0010;
      rst = 1'b1;
      drive(32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      step(); step();
      rst = 1'b0;

      // Reset while an entry is held.
      drive(I_ADDI, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      step();
      chk("pre_reset out_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset out_illegal", 32'(out_illegal), 32'd0);
      chk("reset data", {alu_in1 | alu_in2}, 32'd0);
      chk("reset code", {12'd0, alu_funch, alu_func, alu_mode, out_rd}, 32'd0);

      vecs.push_back('{"addi", I_ADDI, 32'h0, 1'b0, 5'd0, 32'h0,
                       mk_exp(1'b0, 7'h00, 3'd0, 5'b00100, 32'h10, 32'hFFFF_FFFF, 5'd5)});
      vecs.push_back('{"srai", I_SRAI, 32'h0, 1'b0, 5'd0, 32'h0,
                       mk_exp(1'b0, 7'h00, 3'd5, 5'b00100, 32'h2222_2222, 32'd4, 5'd3)});
      vecs.push_back('{"srl", 32'h0011_51B3, 32'h0, 1'b0, 5'd0, 32'h0,
                       mk_exp(1'b0, 7'h20, 3'd5, 5'b01100, 32'h2222_2222, 32'h10, 5'd3)});
      vecs.push_back('{"fwd_rs1", 32'h0001_0233, 32'h0, 1'b1, 5'd2, 32'hDEAD,
                       mk_exp(1'b0, 7'h00, 3'd0, 5'b01100, 32'hDEAD, 32'd0, 5'd4)});
      vecs.push_back('{"fwd_x0", 32'h0050_0313, 32'h0, 1'b1, 5'd0, 32'h1234,
                       mk_exp(1'b0, 7'h00, 3'd0, 5'b00100, 32'd0, 32'd5, 5'd6)});
      vecs.push_back('{"illegal", 32'h0000_007F, 32'h0, 1'b0, 5'd0, 32'h0,
                       mk_exp(1'b1, 7'h00, 3'd0, 5'b11111, 32'd0, 32'd0, 5'd0)});
      vecs.push_back('{"lui", I_LUI, 32'h0, 1'b0, 5'd0, 32'h0,
                       mk_exp(1'b0, 7'h00, 3'd0, 5'b01101, 32'd0, 32'h1234_5000, 5'd7)});
      vecs.push_back('{"auipc", 32'hFFFF_F417, 32'h1000, 1'b0, 5'd0, 32'h0,
                       mk_exp(1'b0, 7'h00, 3'd0, 5'b00101, 32'h1000, 32'hFFFF_F000, 5'd8)});
      vecs.push_back('{"mul", 32'h0220_84B3, 32'h0, 1'b0, 5'd0, 32'h0,
                       mk_exp(1'b0, 7'h01, 3'd0, 5'b01100, 32'h10, 32'h2222_2222, 5'd9)});
      vecs.push_back('{"sub_sll_bad", 32'h4020_91B3, 32'h0, 1'b0, 5'd0, 32'h0,
                       mk_exp(1'b1, 7'h00, 3'd0, 5'b01100, 32'd0, 32'd0, 5'd0)});

      foreach (vecs[i]) begin
         drive(vecs[i].instr, vecs[i].pc, vecs[i].fv, vecs[i].frd, vecs[i].fdata, 1'b1, 1'b1, 1'b0);
         #1;
         chk({vecs[i].name, " in_ready"}, 32'(in_ready), 32'd1);
         step();
         in_valid = 1'b0;
         check_out(vecs[i].name, vecs[i].e);
      end

      // Stall for three cycles, then drain one transfer per cycle.
      e_a = ref_model(I_ADDI, 32'h0, 1'b0, 5'd0, 32'h0);
      e_b = ref_model(I_SRAI, 32'h0, 1'b0, 5'd0, 32'h0);
      e_c = ref_model(I_LUI, 32'h0, 1'b0, 5'd0, 32'h0);
      drive(I_ADDI, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0);
      step();
      drive(I_SRAI, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stall in_ready", 32'(in_ready), 32'd0);
         step();
         check_out("stall hold", e_a);
      end
      out_ready = 1'b1;
      step();
      check_out("drain b", e_b);
      drive(I_LUI, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0);
      step();
      check_out("drain c", e_c);

      // Flush while holding an entry and offering a new one.
      drive(I_ADDI, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1);
      #1;
      chk("flush in_ready", 32'(in_ready), 32'd0);
      step();
      chk("flush out_valid", 32'(out_valid), 32'd0);
      drive(I_ADDI, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
      step();
      chk("flush no capture", 32'(out_valid), 32'd0);

      // Randomized traffic against the reference model.
      m_valid = 1'b0;
      m_e = e_a;
      for (int it = 0; it < 400; it++) begin
         for (int r = 0; r < 32; r++) rf[r] = $urandom;
         ri = $urandom;
         case ($urandom_range(0, 4))
            0: begin
               case ($urandom_range(0, 3))
                  0: f7 = 7'd0;
                  1: f7 = 7'd32;
                  2: f7 = 7'd1;
                  default: f7 = 7'($urandom);
               endcase
               ri = {f7, ri[24:7], 7'b0110011};
            end
            1: begin
               if ($urandom_range(0, 1) == 0) ri[31:25] = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'd32;
               ri = {ri[31:7], 7'b0010011};
            end
            2: ri = {ri[31:7], 7'b0110111};
            3: ri = {ri[31:7], 7'b0010111};
            default: ri = ri;
         endcase
         fv   = 1'($urandom);
         frd  = ($urandom_range(0, 2) == 0) ? ri[19:15] : 5'($urandom);
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 3) != 0);
         fl   = ($urandom_range(0, 15) == 0);
         drive(ri, $urandom, fv, frd, $urandom, iv, ordy, fl);
         #1;
         exp_ready = !fl && (!m_valid || ordy);
         chk("rand in_ready", 32'(in_ready), 32'(exp_ready));
         chk("rand rs_addr", {22'd0, rs1_addr, rs2_addr}, {22'd0, ri[19:15], ri[24:20]});
         e_new = ref_model(ri, pc, fv, frd, fwd_data);
         step();
         if (fl) m_valid = 1'b0;
         else if (iv && exp_ready) begin
            m_valid = 1'b1;
            m_e = e_new;
         end else if (ordy) m_valid = 1'b0;
         chk("rand out_valid", 32'(out_valid), 32'(m_valid));
         if (m_valid) check_out("rand", m_e);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
